// File: rtl/prim_fifo_pack_pkg.sv
// Shared helpers for the width-upsizing packer: lane count and lane-index
// width derived from the input/output word widths.
package prim_fifo_pack_pkg;

    // Returns 0 when OutW is not a whole multiple of InW so the top can reject it.
    function automatic int pack_ratio(input int in_w, input int out_w);
        if (in_w <= 0 || out_w < in_w || (out_w % in_w) != 0) begin
            return 0;
        end
        return out_w / in_w;
    endfunction

    function automatic int lane_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/prim_fifo_pack.sv
// Packs consecutive narrow beats from a FIFO read port into one wide word
// (lane 0 in the LSBs); last_i closes a word early, mask_o marks filled lanes.
module prim_fifo_pack
    import prim_fifo_pack_pkg::*;
#(
    parameter int InW = 16,
    parameter int OutW = 64,
    localparam int Ratio = pack_ratio(InW, OutW),
    localparam int LaneW = lane_w(Ratio)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [InW-1:0]   data_i,
    input  logic             last_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [OutW-1:0]  data_o,
    output logic [Ratio-1:0] mask_o,
    output logic [LaneW-1:0] lane_o
);

    typedef logic [Ratio-1:0] lane_mask_t;

    if (Ratio < 1) begin : g_bad_ratio
        $error("prim_fifo_pack: OutW must be a non-zero multiple of InW");
    end

    logic [OutW-1:0]  acc_reg, acc_next, acc_merged;
    lane_mask_t       acc_mask_reg, acc_mask_next, mask_merged;
    logic [LaneW-1:0] lane_reg, lane_next;
    logic             valid_reg, valid_next;
    logic [OutW-1:0]  data_reg, data_next;
    lane_mask_t       mask_reg, mask_next;

    logic accept, lane_last, complete, out_pop;

    assign ready_o   = !valid_reg || ready_i;
    assign accept    = valid_i && ready_o;
    assign lane_last = (lane_reg == LaneW'(Ratio - 1));
    assign complete  = accept && (lane_last || last_i);
    assign out_pop   = valid_reg && ready_i;

    // The incoming beat is merged combinationally so a completing beat lands
    // in the output register on the same edge it is accepted.
    for (genvar gi = 0; gi < Ratio; gi++) begin : g_lane
        logic lane_en;
        assign lane_en = accept && (lane_reg == LaneW'(gi));
        assign acc_merged[gi*InW +: InW] = lane_en ? data_i : acc_reg[gi*InW +: InW];
        assign mask_merged[gi] = lane_en || acc_mask_reg[gi];
    end

    always_comb begin
        acc_next      = acc_reg;
        acc_mask_next = acc_mask_reg;
        lane_next     = lane_reg;
        valid_next    = valid_reg;
        data_next     = data_reg;
        mask_next     = mask_reg;

        if (clr_i) begin
            acc_next      = '0;
            acc_mask_next = '0;
            lane_next     = '0;
            valid_next    = 1'b0;
            data_next     = '0;
            mask_next     = '0;
        end else if (complete) begin
            // A new word overwrites any word being handed off this cycle.
            valid_next    = 1'b1;
            data_next     = acc_merged;
            mask_next     = mask_merged;
            acc_next      = '0;
            acc_mask_next = '0;
            lane_next     = '0;
        end else begin
            if (accept) begin
                acc_next      = acc_merged;
                acc_mask_next = mask_merged;
                lane_next     = lane_reg + LaneW'(1);
            end
            if (out_pop) begin
                valid_next = 1'b0;
                data_next  = '0;
                mask_next  = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_reg      <= '0;
            acc_mask_reg <= '0;
            lane_reg     <= '0;
            valid_reg    <= 1'b0;
            data_reg     <= '0;
            mask_reg     <= '0;
        end else begin
            acc_reg      <= acc_next;
            acc_mask_reg <= acc_mask_next;
            lane_reg     <= lane_next;
            valid_reg    <= valid_next;
            data_reg     <= data_next;
            mask_reg     <= mask_next;
        end
    end

    assign valid_o = valid_reg;
    assign data_o  = data_reg;
    assign mask_o  = mask_reg;
    assign lane_o  = lane_reg;

endmodule

// File: tb/tb_prim_fifo_pack.sv
// Self-checking bench for prim_fifo_pack (InW=16, OutW=64): a beat-list model
// checked every cycle, plus hand-computed literal expectations per scenario.
module tb_prim_fifo_pack;

    localparam int InW = 16;
    localparam int OutW = 64;
    localparam int Ratio = 4;

    logic             clk = 1'b0;
    logic             rst_i, clr_i, valid_i, last_i, ready_i;
    logic             ready_o, valid_o;
    logic [InW-1:0]   data_i;
    logic [OutW-1:0]  data_o;
    logic [Ratio-1:0] mask_o;
    logic [1:0]       lane_o;

    int n_checks = 0;
    int n_pass = 0;

    prim_fifo_pack #(.InW(InW), .OutW(OutW)) dut (
        .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i),
        .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i), .last_i(last_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .mask_o(mask_o), .lane_o(lane_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: beats of the word being built, and the word on the output register.
    logic [InW-1:0]  cur[$];
    logic            m_valid = 1'b0;
    logic [OutW-1:0] m_data = '0;
    logic [3:0]      m_mask = '0;
    logic [67:0]     emitted[$];

    always @(negedge clk) begin
        if (rst_i) begin
            check("rst_valid", {63'b0, valid_o}, 64'd0);
            check("rst_data", data_o, 64'd0);
            check("rst_mask", {60'b0, mask_o}, 64'd0);
            cur.delete();
            m_valid = 1'b0; m_data = '0; m_mask = '0;
        end else begin
            logic m_ready, acc;
            check("valid_o", {63'b0, valid_o}, {63'b0, m_valid});
            m_ready = !m_valid || ready_i;
            check("ready_o", {63'b0, ready_o}, {63'b0, m_ready});
            check("lane_o", {62'b0, lane_o}, 64'(cur.size()));
            check("data_o", data_o, m_data);
            check("mask_o", {60'b0, mask_o}, {60'b0, m_mask});
            if (valid_o && ready_i && !clr_i) emitted.push_back({mask_o, data_o});
            acc = valid_i && m_ready;
            if (clr_i) begin
                cur.delete();
                m_valid = 1'b0; m_data = '0; m_mask = '0;
            end else begin
                if (acc) cur.push_back(data_i);
                if (acc && (cur.size() == Ratio || last_i)) begin
                    m_data = '0;
                    foreach (cur[i]) m_data |= 64'(cur[i]) << (InW * i);
                    m_mask = 4'((1 << cur.size()) - 1);
                    m_valid = 1'b1;
                    cur.delete();
                end else if (m_valid && ready_i) begin
                    m_valid = 1'b0; m_data = '0; m_mask = '0;
                end
            end
        end
    end

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send(input logic [InW-1:0] d, input logic l);
        bit got = 0;
        valid_i = 1'b1; data_i = d; last_i = l;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            got = ready_o;
            @(posedge clk); #1;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL send_timeout: beat %h never accepted", d);
        end
        valid_i = 1'b0; last_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int base;
        rst_i = 1'b1; clr_i = 1'b0; valid_i = 1'b0; last_i = 1'b0;
        ready_i = 1'b1; data_i = '0;
        idle(2);
        check("reset_lane", {62'b0, lane_o}, 64'd0);
        rst_i = 1'b0;
        idle(1);

        // Full word of four beats.
        send(16'h1111, 0); send(16'h2222, 0); send(16'h3333, 0); send(16'h4444, 0);
        check("full_valid", {63'b0, valid_o}, 64'd1);
        check("full_data", data_o, 64'h4444_3333_2222_1111);
        check("full_mask", {60'b0, mask_o}, 64'hF);
        check("full_lane", {62'b0, lane_o}, 64'd0);
        idle(2);

        // Early close with last_i on lane 1, then next beat restarts at lane 0.
        send(16'hAAAA, 0); send(16'hBBBB, 1);
        check("last_data", data_o, 64'h0000_0000_BBBB_AAAA);
        check("last_mask", {60'b0, mask_o}, 64'h3);
        send(16'hCCCC, 0);
        check("after_last_lane", {62'b0, lane_o}, 64'd1);
        send(16'hDDDD, 1);
        check("two_lane_word", data_o, 64'h0000_0000_DDDD_CCCC);
        idle(1);

        // Single-lane word from last_i on lane 0.
        send(16'h0E0E, 1);
        check("single_mask", {60'b0, mask_o}, 64'h1);
        check("single_data", data_o, 64'h0000_0000_0000_0E0E);
        idle(1);

        // Back-pressure: word held for 5 cycles while the next beat waits.
        ready_i = 1'b0;
        send(16'h5001, 0); send(16'h5002, 0); send(16'h5003, 0); send(16'h5004, 0);
        valid_i = 1'b1; data_i = 16'h6001;
        for (int c = 0; c < 5; c++) begin
            check("stall_ready", {63'b0, ready_o}, 64'd0);
            check("stall_data", data_o, 64'h5004_5003_5002_5001);
            idle(1);
        end
        ready_i = 1'b1;
        send(16'h6001, 0); send(16'h6002, 0); send(16'h6003, 0); send(16'h6004, 0);
        check("post_stall_data", data_o, 64'h6004_6003_6002_6001);
        idle(2);

        // Continuous stream: three full words.
        base = emitted.size();
        for (int i = 0; i < 12; i++) send(16'h7000 + 16'(i), 0);
        idle(2);
        check("stream_words", 64'(emitted.size() - base), 64'd3);
        if (emitted.size() >= base + 3) begin
            check("stream_w0", emitted[base][63:0], 64'h7003_7002_7001_7000);
            check("stream_w2", emitted[base+2][63:0], 64'h700B_700A_7009_7008);
            check("stream_m1", {60'b0, emitted[base+1][67:64]}, 64'hF);
        end

        // Synchronous clear discards a partial word.
        send(16'h8001, 0); send(16'h8002, 0);
        clr_i = 1'b1; idle(1); clr_i = 1'b0;
        check("clr_valid", {63'b0, valid_o}, 64'd0);
        check("clr_lane", {62'b0, lane_o}, 64'd0);
        send(16'h9001, 0); send(16'h9002, 0); send(16'h9003, 0); send(16'h9004, 0);
        check("clr_clean_data", data_o, 64'h9004_9003_9002_9001);
        check("clr_clean_mask", {60'b0, mask_o}, 64'hF);
        idle(1);

        // Async reset while a word is held.
        ready_i = 1'b0;
        send(16'hA001, 0); send(16'hA002, 0); send(16'hA003, 0); send(16'hA004, 0);
        #3 rst_i = 1'b1;
        #1 check("arst_valid", {63'b0, valid_o}, 64'd0);
        check("arst_data", data_o, 64'd0);
        idle(1); rst_i = 1'b0; ready_i = 1'b1;

        // Async reset in FILL with lane at 2.
        send(16'hB001, 0); send(16'hB002, 0);
        check("fill_lane2", {62'b0, lane_o}, 64'd2);
        #3 rst_i = 1'b1;
        #1 check("arst_lane", {62'b0, lane_o}, 64'd0);
        idle(1); rst_i = 1'b0;
        send(16'hC001, 0);
        check("arst_first_lane", {62'b0, lane_o}, 64'd1);
        send(16'hC002, 0); send(16'hC003, 0); send(16'hC004, 0);
        check("arst_word", data_o, 64'hC004_C003_C002_C001);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
